// File: rtl/axis_arb_config.sv
// Shared types and default sizing for the processor arbiter and its tag FIFO.
package axis_arb_config;
  localparam int DEF_NUM_SRC   = 4;
  localparam int DEF_MAX_BURST = 8;
  localparam int DEF_TAG_DEPTH = 16;

  localparam int SRC_W = $clog2(DEF_NUM_SRC);
  typedef logic [SRC_W-1:0] src_idx_t;

  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/processor_config.sv
// Datapath widths of the shared axis_processor; the arbiter inherits its
// forward and return widths from here.
package processor_config;
  localparam int INP_WIDTH = 8;
  localparam int OUT_WIDTH = 16;
endpackage

// File: rtl/sync_tag_fifo.sv
// Small synchronous FIFO holding the source index of every beat in flight
// inside the processor; head is read combinationally from the read pointer.
module sync_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Full is taken from the registered count, so a pop cannot make room for a push in the same cycle.
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/axis_proc_arbiter.sv
// Round-robin burst arbiter sharing one axis_processor among NUM_SRC streams;
// in-order results are routed back to their requester via a source-tag FIFO.
module axis_proc_arbiter
  import axis_arb_config::*;
#(
  parameter int NUM_SRC   = DEF_NUM_SRC,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH,
  parameter int INP_WIDTH = processor_config::INP_WIDTH,
  parameter int OUT_WIDTH = processor_config::OUT_WIDTH
) (
  input  logic                         clk,
  input  logic                         arstn,
  input  logic [NUM_SRC*INP_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]           s_axis_tvalid,
  output logic [NUM_SRC-1:0]           s_axis_tready,
  output logic [INP_WIDTH-1:0]         p_axis_tdata,
  output logic                         p_axis_tvalid,
  input  logic                         p_axis_tready,
  input  logic [OUT_WIDTH-1:0]         r_axis_tdata,
  input  logic                         r_axis_tvalid,
  output logic                         r_axis_tready,
  output logic [NUM_SRC*OUT_WIDTH-1:0] m_axis_tdata,
  output logic [NUM_SRC-1:0]           m_axis_tvalid,
  input  logic [NUM_SRC-1:0]           m_axis_tready,
  output logic                         err
);
  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             err_q, err_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] grant_next;
  logic             fwd_beat;

  logic             tag_push;
  logic             tag_pop;
  logic [IDX_W-1:0] tag_head;
  logic             tag_full;
  logic             tag_empty;

  // Scan from the highest offset down so the candidate closest to rr_ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_SRC)) cand = cand - (IDX_W+1)'(NUM_SRC);
      if (s_axis_tvalid[cand[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign grant_next = (grant_q == IDX_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    beat_cnt_d    = beat_cnt_q;
    err_d         = err_q | (r_axis_tvalid & tag_empty);
    p_axis_tdata  = s_axis_tdata[grant_q*INP_WIDTH +: INP_WIDTH];
    p_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    fwd_beat      = 1'b0;
    tag_push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        p_axis_tvalid          = s_axis_tvalid[grant_q] & ~tag_full;
        s_axis_tready[grant_q] = p_axis_tready & ~tag_full;
        fwd_beat               = p_axis_tvalid & p_axis_tready;
        tag_push               = fwd_beat;
        if (fwd_beat) beat_cnt_d = beat_cnt_q + 1'b1;
        // A full tag FIFO only stalls the burst; the grant is kept while the source stays valid.
        if ((fwd_beat && beat_cnt_q == CNT_W'(MAX_BURST - 1)) || !s_axis_tvalid[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = grant_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  sync_tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .arstn (arstn),
    .push  (tag_push),
    .pop   (tag_pop),
    .din   (grant_q),
    .head  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ret_data
      assign m_axis_tdata[gi*OUT_WIDTH +: OUT_WIDTH] = r_axis_tdata;
    end
  endgenerate

  always_comb begin
    m_axis_tvalid           = '0;
    m_axis_tvalid[tag_head] = r_axis_tvalid & ~tag_empty;
    r_axis_tready           = m_axis_tready[tag_head] & ~tag_empty;
    tag_pop                 = r_axis_tvalid & r_axis_tready;
  end

  assign err = err_q;
endmodule

// File: tb/tb_axis_proc_arbiter.sv
// Directed bench for axis_proc_arbiter with a behavioural processor model
// (result = {~x, x}, one cycle latency, 32-entry queue) between p_* and r_*.
module tb_axis_proc_arbiter;
  localparam int NS = 4;
  localparam int IW = 8;
  localparam int OW = 16;

  logic             clk = 1'b0;
  logic             arstn;
  logic [NS*IW-1:0] s_tdata;
  logic [NS-1:0]    s_tvalid, s_tready;
  logic [IW-1:0]    p_tdata;
  logic             p_tvalid, p_tready;
  logic [OW-1:0]    r_tdata;
  logic             r_tvalid, r_tready;
  logic [NS*OW-1:0] m_tdata;
  logic [NS-1:0]    m_tvalid, m_tready;
  logic             err;

  logic [IW-1:0] srcq [NS][$];
  logic [OW-1:0] expq [NS][$];
  logic [IW-1:0] procq [$];
  int            fwd_src [$];
  int            delivered [NS];
  int            fwd_beats;
  logic [NS-1:0] mready;
  logic          bypass, force_rv;
  int            n_cmp = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  axis_proc_arbiter #(
    .NUM_SRC(NS), .MAX_BURST(8), .TAG_DEPTH(16), .INP_WIDTH(IW), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk), .arstn(arstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .p_axis_tdata(p_tdata), .p_axis_tvalid(p_tvalid), .p_axis_tready(p_tready),
    .r_axis_tdata(r_tdata), .r_axis_tvalid(r_tvalid), .r_axis_tready(r_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .err(err)
  );

  function automatic logic [OW-1:0] f(input logic [IW-1:0] x);
    return {~x, x};
  endfunction

  task automatic load(input int s, input logic [IW-1:0] d);
    srcq[s].push_back(d);
    expq[s].push_back(f(d));
  endtask

  task automatic clear_all();
    for (int i = 0; i < NS; i++) begin
      srcq[i].delete();
      expq[i].delete();
      delivered[i] = 0;
    end
    procq.delete();
    fwd_src.delete();
    fwd_beats = 0;
    mready    = '1;
    bypass    = 1'b0;
    force_rv  = 1'b0;
  endtask

  // One clock: drive after negedge, sample 1 ns before posedge, update models.
  task automatic step();
    int src, nr;
    for (int i = 0; i < NS; i++) begin
      s_tvalid[i] = (srcq[i].size() > 0);
      s_tdata[i*IW +: IW] = (srcq[i].size() > 0) ? srcq[i][0] : '0;
    end
    p_tready = (procq.size() < 32);
    if (bypass) begin
      r_tvalid = force_rv;
      r_tdata  = 16'hDEAD;
    end else begin
      r_tvalid = (procq.size() > 0);
      r_tdata  = (procq.size() > 0) ? f(procq[0]) : '0;
    end
    m_tready = mready;
    #4;
    n_cmp++;
    if (p_tvalid === 1'b1 && p_tready) begin
      nr = 0; src = 0;
      for (int i = 0; i < NS; i++) if (s_tready[i] === 1'b1) begin nr++; src = i; end
      if (nr != 1) begin
        n_fail++;
        $display("FAIL fwd_onehot: s_tready=%b got %0d ready, want 1", s_tready, nr);
      end else begin
        n_cmp++;
        if (p_tdata !== srcq[src][0]) begin
          n_fail++;
          $display("FAIL fwd_data: src%0d p_tdata=%0h want %0h", src, p_tdata, srcq[src][0]);
        end
        srcq[src].pop_front();
        fwd_src.push_back(src);
      end
      procq.push_back(p_tdata);
      fwd_beats++;
      $display("fwd beat %0d src%0d data %0h", fwd_beats, src, p_tdata);
    end else begin
      for (int i = 0; i < NS; i++)
        if (s_tvalid[i] && s_tready[i] === 1'b1) begin
          n_fail++;
          $display("FAIL stray_accept: src%0d accepted without p beat, got 1 want 0", i);
        end
    end
    if (!bypass && r_tvalid && r_tready === 1'b1) void'(procq.pop_front());
    for (int i = 0; i < NS; i++) begin
      if (m_tvalid[i] === 1'b1 && m_tready[i]) begin
        n_cmp++;
        if (expq[i].size() == 0) begin
          n_fail++;
          $display("FAIL ret_unexpected: src%0d data %0h, want no result", i, m_tdata[i*OW +: OW]);
        end else begin
          if (m_tdata[i*OW +: OW] !== expq[i][0]) begin
            n_fail++;
            $display("FAIL ret_data: src%0d got %0h want %0h", i, m_tdata[i*OW +: OW], expq[i][0]);
          end
          void'(expq[i].pop_front());
        end
        delivered[i]++;
        $display("ret beat src%0d data %0h", i, m_tdata[i*OW +: OW]);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_all();
    arstn = 1'b0;
    step();
    step();
    arstn = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    n_cmp++;
    if (s_tready !== '0 || p_tvalid !== 1'b0 || m_tvalid !== '0 || r_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: s_tready=%b p_tvalid=%b m_tvalid=%b r_tready=%b, want all 0",
               tag, s_tready, p_tvalid, m_tvalid, r_tready);
    end
  endtask

  task automatic test_reset();
    clear_all();
    for (int i = 0; i < NS; i++) load(i, 8'hE0 + 8'(i));
    arstn = 1'b0;
    step();
    step();
    check_idle_outputs("reset_outputs");
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    clear_all();
    arstn = 1'b1;
  endtask

  task automatic test_single_src();
    do_reset();
    load(2, 8'h11); load(2, 8'h22); load(2, 8'h33);
    step();
    n_cmp++;
    if (fwd_beats != 0) begin n_fail++; $display("FAIL idle_bubble: got %0d beats want 0", fwd_beats); end
    repeat (3) step();
    n_cmp++;
    if (fwd_beats != 3) begin n_fail++; $display("FAIL single_beats: got %0d want 3", fwd_beats); end
    for (int t = 0; t < 20 && delivered[2] < 3; t++) step();
    n_cmp++;
    if (delivered[2] != 3) begin n_fail++; $display("FAIL single_deliver: got %0d want 3", delivered[2]); end
    // rr_ptr must now be 3: with all sources valid, 3 wins first, then 0,1,2.
    for (int i = 0; i < NS; i++) load(i, 8'h50 + 8'(i));
    for (int t = 0; t < 40 && fwd_beats < 7; t++) step();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (fwd_beats < 3 + k + 1 || fwd_src[3+k] != (3 + k) % NS) begin
        n_fail++;
        $display("FAIL rr_after_single: grant %0d got src%0d want src%0d", k,
                 (fwd_beats > 3 + k) ? fwd_src[3+k] : -1, (3 + k) % NS);
      end
    end
    for (int t = 0; t < 20; t++) step();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NS; i++)
      for (int k = 0; k < 16; k++) load(i, 8'((i << 4) | k));
    for (int t = 0; t < 300 && fwd_beats < 64; t++) step();
    n_cmp++;
    if (fwd_beats != 64) begin n_fail++; $display("FAIL rr_beats: got %0d want 64", fwd_beats); end
    for (int k = 0; k < fwd_beats && k < 64; k++) begin
      n_cmp++;
      if (fwd_src[k] != (k / 8) % NS) begin
        n_fail++;
        $display("FAIL rr_order: beat %0d got src%0d want src%0d", k, fwd_src[k], (k / 8) % NS);
      end
    end
    for (int t = 0; t < 100; t++) step();
    for (int i = 0; i < NS; i++) begin
      n_cmp++;
      if (delivered[i] != 16) begin n_fail++; $display("FAIL rr_deliver: src%0d got %0d want 16", i, delivered[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mready = 4'b1101;
    for (int k = 0; k < 20; k++) load(1, 8'h40 + 8'(k));
    repeat (40) step();
    n_cmp++;
    if (fwd_beats != 16) begin n_fail++; $display("FAIL bp_inflight: got %0d beats want 16", fwd_beats); end
    n_cmp++;
    if (p_tvalid !== 1'b0 || s_tready[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall: p_tvalid=%b s_tready1=%b want 0 0", p_tvalid, s_tready[1]);
    end
    n_cmp++;
    if (r_tvalid !== 1'b1 || r_tready !== 1'b0 || delivered[1] != 0) begin
      n_fail++;
      $display("FAIL bp_return: r_tvalid=%b r_tready=%b delivered=%0d want 1 0 0", r_tvalid, r_tready, delivered[1]);
    end
    mready = '1;
    for (int t = 0; t < 200 && delivered[1] < 20; t++) step();
    n_cmp++;
    if (delivered[1] != 20) begin n_fail++; $display("FAIL bp_deliver: got %0d want 20", delivered[1]); end
  endtask

  task automatic test_err();
    do_reset();
    bypass   = 1'b1;
    force_rv = 1'b1;
    step();
    n_cmp++;
    if (err !== 1'b1 || r_tready !== 1'b0 || m_tvalid !== '0) begin
      n_fail++;
      $display("FAIL err_set: err=%b r_tready=%b m_tvalid=%b want 1 0 0", err, r_tready, m_tvalid);
    end
    force_rv = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
    do_reset();
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    for (int k = 0; k < 16; k++) load(0, 8'hA0 + 8'(k));
    repeat (4) step();
    n_cmp++;
    if (fwd_beats != 3) begin n_fail++; $display("FAIL mid_pre: got %0d beats want 3", fwd_beats); end
    arstn = 1'b0;
    step();
    check_idle_outputs("mid_reset_outputs");
    n_cmp++;
    if (r_tvalid !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_state: r_tvalid=%b err=%b want 1 0", r_tvalid, err);
    end
    clear_all();
    step();
    arstn = 1'b1;
  endtask

  initial begin
    arstn    = 1'b0;
    s_tvalid = '0;
    s_tdata  = '0;
    p_tready = 1'b0;
    r_tvalid = 1'b0;
    r_tdata  = '0;
    m_tready = '0;
    clear_all();
    @(negedge clk);
    test_reset();
    test_single_src();
    test_round_robin();
    test_backpressure();
    test_err();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
